// File: rtl/counter_pkg.sv
// Shared types and defaults for the run-control counter block.
package counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down counter; load has priority over stepping.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= dir ? q - 1'b1 : q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-control FSM and configuration registers around an up/down counter,
// supporting one-shot or auto-reload runs with pause/hold and abort.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_term,
  input  logic             cfg_dir,
  input  logic             cfg_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] term;
  logic             dir;
  logic             reload;

  logic             cfg_acc;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] launch_val;
  logic             at_end;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             step_en;

  assign cfg_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign start_val  = dir ? term : '0;
  assign end_val    = dir ? '0 : term;
  // A configuration accepted in the same cycle as start decides the launch value.
  assign launch_val = cfg_acc ? (cfg_dir ? cfg_term : '0) : start_val;
  assign at_end     = (count == end_val);
  assign tc         = !rst && (state == ST_RUN) && !pause && at_end;
  assign busy       = (state == ST_RUN) || (state == ST_HOLD);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_val    = start_val;
    step_en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          ld        = 1'b1;
          ld_val    = launch_val;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          ld        = 1'b1;
          ld_val    = '0;
        end else if (pause) begin
          state_nxt = ST_HOLD;
        end else if (at_end) begin
          if (reload) begin
            ld = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          step_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          ld        = 1'b1;
          ld_val    = '0;
        end else if (!pause) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      term   <= '1;
      dir    <= 1'b0;
      reload <= 1'b1;
    end else begin
      state <= state_nxt;
      if (cfg_acc) begin
        term   <= cfg_term;
        dir    <= cfg_dir;
        reload <= cfg_reload;
      end
    end
  end

  updown_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .load_val(ld_val),
    .en      (step_en),
    .dir     (dir),
    .q       (count)
  );

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: expectations queued per cycle, checked mid-cycle.
module tb_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         pause;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_term;
  logic         cfg_dir;
  logic         cfg_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  counter_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_term  (cfg_term),
    .cfg_dir   (cfg_dir),
    .cfg_reload(cfg_reload),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         done;
    logic         rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic setcfg(input logic v, input int t, input logic d, input logic r);
    cfg_valid  = v;
    cfg_term   = W'(t);
    cfg_dir    = d;
    cfg_reload = r;
  endtask

  // Queue the expected outputs for the current cycle, then compare and advance.
  task automatic cyc(input string tag, input int cnt, input logic etc, input logic eb,
                     input logic ed, input logic er);
    exp_t e;
    e.tag  = tag;
    e.cnt  = W'(cnt);
    e.tc   = etc;
    e.busy = eb;
    e.done = ed;
    e.rdy  = er;
    sb.push_back(e);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".count"}, count, e.cnt);
      chk({e.tag, ".tc"}, W'(tc), W'(e.tc));
      chk({e.tag, ".busy"}, W'(busy), W'(e.busy));
      chk({e.tag, ".done"}, W'(done), W'(e.done));
      chk({e.tag, ".cfg_ready"}, W'(cfg_ready), W'(e.rdy));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    setcfg(0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("reset", 0, 0, 0, 0, 1);

    // Defaults: T=15, up, auto-reload
    start = 1'b1; cyc("t1_start", 0, 0, 0, 0, 1); start = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("t1_c%0d", i), i, i == 15, 1, 0, 0);
    cyc("t1_wrap0", 0, 0, 1, 0, 0);
    cyc("t1_wrap1", 1, 0, 1, 0, 0);
    stop = 1'b1; cyc("t1_stop", 2, 0, 1, 0, 0); stop = 1'b0;
    cyc("t1_idle", 0, 0, 0, 0, 1);

    // One-shot down count from 5, then restart from DONE with new T and a stray stop
    setcfg(1, 5, 1, 0); cyc("t2_cfg", 0, 0, 0, 0, 1); cfg_valid = 1'b0;
    start = 1'b1; cyc("t2_start", 0, 0, 0, 0, 1); start = 1'b0;
    for (int i = 0; i < 6; i++) cyc($sformatf("t2_c%0d", 5 - i), 5 - i, i == 5, 1, 0, 0);
    cyc("t2_done", 0, 0, 0, 1, 1);
    cyc("t2_hold", 0, 0, 0, 1, 1);
    setcfg(1, 7, 0, 0); start = 1'b1; stop = 1'b1;
    cyc("t2_restart", 0, 0, 0, 1, 1);
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 8; i++) cyc($sformatf("t2_n%0d", i), i, i == 7, 1, 0, 0);
    cyc("t2_done7", 7, 0, 0, 1, 1);

    // T=9 up: config blocked while running, pause/hold, stop+pause abort, restart
    setcfg(1, 9, 0, 1); start = 1'b1; cyc("t3_start", 7, 0, 0, 1, 1); start = 1'b0;
    setcfg(1, 2, 1, 0); cyc("t3_cfg_run", 0, 0, 1, 0, 0); cfg_valid = 1'b0;
    for (int i = 1; i < 4; i++) cyc($sformatf("t3_c%0d", i), i, 0, 1, 0, 0);
    pause = 1'b1;
    cyc("t3_pause", 4, 0, 1, 0, 0);
    cyc("t3_hold1", 4, 0, 1, 0, 0);
    cyc("t3_hold2", 4, 0, 1, 0, 0);
    pause = 1'b0;
    cyc("t3_resume", 4, 0, 1, 0, 0);
    cyc("t3_run4", 4, 0, 1, 0, 0);
    cyc("t3_c5", 5, 0, 1, 0, 0);
    stop = 1'b1; pause = 1'b1; cyc("t3_stop", 6, 0, 1, 0, 0); stop = 1'b0; pause = 1'b0;
    cyc("t3_idle", 0, 0, 0, 0, 1);
    start = 1'b1; cyc("t3_restart", 0, 0, 0, 0, 1); start = 1'b0;
    for (int i = 0; i < 10; i++) cyc($sformatf("t3_r%0d", i), i, i == 9, 1, 0, 0);
    cyc("t3_wrap", 0, 0, 1, 0, 0);
    stop = 1'b1; cyc("t3_stop2", 1, 0, 1, 0, 0); stop = 1'b0;

    // T=0 auto-reload, then reset mid-run restores defaults
    setcfg(1, 0, 0, 1); start = 1'b1; cyc("t4_start", 0, 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b0;
    cyc("t4_c1", 0, 1, 1, 0, 0);
    cyc("t4_c2", 0, 1, 1, 0, 0);
    rst = 1'b1; cyc("t4_rst", 0, 0, 1, 0, 0); rst = 1'b0;
    cyc("t4_idle", 0, 0, 0, 0, 1);
    start = 1'b1; cyc("t4_restart", 0, 0, 0, 0, 1); start = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("t4_d%0d", i), i, i == 15, 1, 0, 0);
    cyc("t4_wrap", 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and terminal-value width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL request a run (one-cycle pulse or level).
REQ-005 stop  input  1  SHALL abort a run.
REQ-006 pause  input  1  SHALL be a level that freezes counting while high.
REQ-007 cfg_valid  input  1  SHALL qualify cfg_term, cfg_dir and cfg_reload.
REQ-008 cfg_ready  output  1  SHALL indicate that configuration is accepted this cycle.
REQ-009 cfg_term  input  WIDTH  SHALL be the terminal value T; the count range is 0..T.
REQ-010 cfg_dir  input  1  SHALL select the direction: 0 = up, 1 = down.
REQ-011 cfg_reload  input  1  SHALL select the mode: 1 = auto-reload, 0 = one-shot.
REQ-012 count  output  WIDTH  SHALL be the current count, registered.
REQ-013 tc  output  1  SHALL be the terminal-count strobe.
REQ-014 busy  output  1  SHALL be high in RUN or HOLD.
REQ-015 done  output  1  SHALL be high in DONE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, HOLD, DONE.
REQ-017 cfg_ready SHALL be 1 only in IDLE or DONE; on cfg_valid&cfg_ready the T, dir and reload registers SHALL load next edge.
REQ-018 Start value S SHALL be 0 when dir=0 and T when dir=1; end value E SHALL be T when dir=0 and 0 when dir=1.
REQ-019 IDLE/DONE with start=1: state SHALL go to RUN and count SHALL load S next edge; first step one cycle later.
REQ-020 cfg handshake and start in the same cycle SHALL use the newly accepted configuration for S.
REQ-021 In RUN with pause=0 and count!=E, count SHALL step by one per cycle (up: +1, down: -1), no wrap past range.
REQ-022 tc SHALL be combinational, equal to (state==RUN && pause==0 && count==E), and high for exactly one cycle per terminal reach.
REQ-023 At tc with reload=1: count SHALL load S and state SHALL stay RUN.
REQ-024 At tc with reload=0: state SHALL go to DONE and count SHALL hold E.
REQ-025 RUN with pause=1: count SHALL hold, tc=0, next state HOLD.
REQ-026 HOLD with pause=0: count SHALL hold one more cycle; next state RUN.
REQ-027 stop in RUN or HOLD SHALL take priority over pause, start and tc: next state IDLE, count 0.
REQ-028 stop in IDLE or DONE SHALL be ignored; start SHALL then be honoured.
REQ-029 start in RUN or HOLD SHALL be ignored.
REQ-030 T=0 SHALL give count constantly 0; with reload=1, tc SHALL be high every unpaused RUN cycle.
REQ-031 A DONE-to-RUN restart via start SHALL behave identically to REQ-019.

Reset
REQ-032 rst=1 SHALL on the next edge force: state IDLE, count 0, T all-ones, dir 0, reload 1.
REQ-033 The resulting outputs SHALL be: tc 0, busy 0, done 0, cfg_ready 1.
REQ-034 rst SHALL override every other input, including mid-run; no tc SHALL be emitted in the reset cycle.

Structure
REQ-035 Shared package counter_pkg SHALL hold the state enumeration and the default WIDTH constant.
REQ-036 Datapath SHALL be one sub-module updown_counter (WIDTH; ports clk, rst, load, load_val, en, dir, q); counter_ctrl SHALL hold the FSM and config registers.

Verification
REQ-037 Reset then start, defaults → count 0,1,...,15,0,1; tc high only at count=15; busy=1.
REQ-038 cfg T=5, dir=1, reload=0, then start → count 5,4,3,2,1,0; tc at 0; done=1; count holds 0; cfg_ready=1.
REQ-039 T=9 up run, pause high at count=4 for 3 cycles → count stays 4 through HOLD plus one resume cycle, then 5; no tc.
REQ-040 T=9 up run, stop and pause together at count=6 → next cycle IDLE, count 0, busy 0; a later start restarts from 0.
REQ-041 T=0, reload=1, start → count 0, tc high every cycle; rst at cycle 3 → next cycle IDLE, T=15, tc 0.
REQ-042 cfg_valid while RUN → cfg_ready=0, config unchanged; cfg and start together in DONE → run uses new T.
